seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 8-digit 7-segment display on the FPGA board.
//  It cycles a digit index sel[2:0] that feeds the active-low anode select decoder,
//  and drives the matching active-low cathode pattern for that digit.
//  New 32-bit hex display values are staged and committed only at a frame boundary,
//  so a frame never shows a mix of old and new digits.

---
 rtl/seg_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit 7-segment display.
//   Cycles a digit index (sel) at REFRESH_DIV clocks per digit and drives the
//   active-low cathode pattern of that digit. New display data is staged on load
//   and committed only at a frame boundary, so a frame never mixes old and new digits.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   disp_value   eight hex nibbles, nibble k = digit k
//   disp_blank   1 = digit k dark (segments and dp off)
//   disp_dp      1 = decimal point of digit k lit
//   load         1-cycle request to stage disp_value/blank/dp
//   load_ack     1-cycle pulse when staged data is committed
//   sel          digit index for the anode decoder, 0..7
//   cathode      active-low {dp,g,f,e,d,c,b,a} for digit sel
//   frame_tick   1-cycle pulse in the first cycle of each frame (sel == 0)
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DIV_W       = $clog2(REFRESH_DIV)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] disp_value,
    input  logic [7:0]  disp_blank,
    input  logic [7:0]  disp_dp,
    input  logic        load,
    output logic        load_ack,
    output logic [2:0]  sel,
    output logic [7:0]  cathode,
    output logic        frame_tick
);

    localparam int unsigned SEL_W = 3;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(7);

    // One complete display image: value nibbles, per-digit blank and dp
    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  blank;
        logic [7:0]  dp;
    } disp_t;

    localparam disp_t DISP_DARK = '{value: 32'h0, blank: 8'hFF, dp: 8'h00};

    logic [DIV_W-1:0] div_cnt, div_cnt_n;
    logic [SEL_W-1:0] sel_n;
    logic             pending, pending_n;
    disp_t            staging, staging_n;
    disp_t            shadow, shadow_n;
    logic [7:0]       cathode_n;
    logic             load_ack_n;
    logic             frame_tick_n;
    logic             tc;
    logic             fb;
    logic             commit;
    logic [3:0]       digit;

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            sel        <= '0;
            pending    <= 1'b0;
            staging    <= '0;
            shadow     <= DISP_DARK;
            cathode    <= 8'hFF;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= div_cnt_n;
            sel        <= sel_n;
            pending    <= pending_n;
            staging    <= staging_n;
            shadow     <= shadow_n;
            cathode    <= cathode_n;
            load_ack   <= load_ack_n;
            frame_tick <= frame_tick_n;
        end
    end

    // Next state: prescaler, digit scan, staging and frame-boundary commit
    always_comb begin
        div_cnt_n = div_cnt + DIV_W'(1);
        sel_n     = sel;
        pending_n = pending;
        staging_n = staging;
        shadow_n  = shadow;

        tc     = (div_cnt == DIV_LAST);
        fb     = tc && (sel == SEL_LAST);
        commit = fb && pending;

        if (tc) begin
            div_cnt_n = '0;
            sel_n     = sel + SEL_W'(1);
        end

        // Commit uses the staging contents from before this edge
        if (commit) begin
            shadow_n = staging;
        end

        // A load always stages and re-arms pending, even in the fb cycle
        if (load) begin
            staging_n = '{value: disp_value, blank: disp_blank, dp: disp_dp};
            pending_n = 1'b1;
        end else if (fb) begin
            pending_n = 1'b0;
        end
    end

    // Output next values: cathode follows the post-commit shadow at the new sel
    always_comb begin
        digit        = shadow_n.value[{sel_n, 2'b00} +: 4];
        cathode_n    = {~shadow_n.dp[sel_n], seg7(digit)};
        load_ack_n   = commit;
        frame_tick_n = fb;
        if (shadow_n.blank[sel_n]) begin
            cathode_n = 8'hFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with REFRESH_DIV = 4
//   (one digit every 4 clocks, one frame every 32 clocks).
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] disp_value;
    logic [7:0]  disp_blank;
    logic [7:0]  disp_dp;
    logic        load;
    logic        load_ack;
    logic [2:0]  sel;
    logic [7:0]  cathode;
    logic        frame_tick;

    int checks;
    int errors;
    int ack_cnt;
    int tick_cnt;
    int lit_cnt;

    logic [7:0] obs_cat [8];
    logic [2:0] obs_sel [8];

    seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_value (disp_value),
        .disp_blank (disp_blank),
        .disp_dp    (disp_dp),
        .load       (load),
        .load_ack   (load_ack),
        .sel        (sel),
        .cathode    (cathode),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Advance to the next falling edge and tally observed pulses
    task automatic step();
        @(negedge clk);
        if (load_ack === 1'b1) ack_cnt++;
        if (frame_tick === 1'b1) tick_cnt++;
        if (cathode !== 8'hFF) lit_cnt++;
    endtask

    // One-cycle load request issued at the current falling edge
    task automatic load_word(input logic [31:0] v, input logic [7:0] b, input logic [7:0] d);
        disp_value = v;
        disp_blank = b;
        disp_dp    = d;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    // Record sel/cathode of each digit; starts on a frame_tick edge, ends on the next
    task automatic capture_frame();
        ack_cnt = 0;
        for (int d = 0; d < 8; d++) begin
            obs_sel[d] = sel;
            obs_cat[d] = cathode;
            repeat (4) step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        disp_value = '0;
        disp_blank = '0;
        disp_dp = '0;
        load = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
        checks++;
        if (cathode !== 8'hFF) begin errors++; $display("FAIL reset_cathode got %h exp ff", cathode); end
        checks++;
        if (load_ack !== 1'b0 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got ack=%b tick=%b exp 0 0", load_ack, frame_tick);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan_idle();
        ack_cnt = 0;
        tick_cnt = 0;
        lit_cnt = 0;
        for (int k = 1; k <= 64; k++) begin
            step();
            checks++;
            if (sel !== 3'((k / 4) % 8)) begin
                errors++; $display("FAIL t1_sel k=%0d got %0d exp %0d", k, sel, (k / 4) % 8);
            end
            checks++;
            if (frame_tick !== ((k % 32) == 0)) begin
                errors++; $display("FAIL t1_tick k=%0d got %b exp %b", k, frame_tick, (k % 32) == 0);
            end
        end
        checks++;
        if (lit_cnt != 0) begin errors++; $display("FAIL t1_dark got %0d lit cycles exp 0", lit_cnt); end
        checks++;
        if (ack_cnt != 0) begin errors++; $display("FAIL t1_ack got %0d exp 0", ack_cnt); end
        checks++;
        if (tick_cnt != 2) begin errors++; $display("FAIL t1_ticks got %0d exp 2", tick_cnt); end
    endtask

    task automatic test_load_basic();
        logic [7:0] exp [8];
        exp = '{8'h40, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
        ack_cnt = 0;
        load_word(32'h76543210, 8'h00, 8'h01);
        repeat (31) step();
        checks++;
        if (load_ack !== 1'b1 || frame_tick !== 1'b1) begin
            errors++; $display("FAIL t2_ack_with_tick got ack=%b tick=%b exp 1 1", load_ack, frame_tick);
        end
        checks++;
        if (ack_cnt != 1) begin errors++; $display("FAIL t2_ack_count got %0d exp 1", ack_cnt); end
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (obs_sel[d] !== 3'(d) || obs_cat[d] !== exp[d]) begin
                errors++; $display("FAIL t2_digit%0d got sel=%0d cat=%h exp sel=%0d cat=%h",
                                   d, obs_sel[d], obs_cat[d], d, exp[d]);
            end
        end
        checks++;
        if (ack_cnt != 0) begin errors++; $display("FAIL t2_no_reack got %0d exp 0", ack_cnt); end
    endtask

    task automatic test_last_wins();
        ack_cnt = 0;
        load_word(32'h11111111, 8'h00, 8'h00);
        repeat (5) step();
        load_word(32'hFFFFFFFF, 8'h00, 8'h00);
        repeat (25) step();
        checks++;
        if (ack_cnt != 1 || load_ack !== 1'b1) begin
            errors++; $display("FAIL t3_single_ack got cnt=%0d ack=%b exp 1 1", ack_cnt, load_ack);
        end
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (obs_cat[d] !== 8'h8E) begin
                errors++; $display("FAIL t3_digit%0d got %h exp 8e", d, obs_cat[d]);
            end
        end
        checks++;
        if (ack_cnt != 0) begin errors++; $display("FAIL t3_no_reack got %0d exp 0", ack_cnt); end
    endtask

    task automatic test_load_at_fb();
        ack_cnt = 0;
        load_word(32'h00000000, 8'h00, 8'h00);
        repeat (30) step();
        checks++;
        if (sel !== 3'd7) begin errors++; $display("FAIL t4_fb_cycle_sel got %0d exp 7", sel); end
        load_word(32'h22222222, 8'h00, 8'h00);
        checks++;
        if (load_ack !== 1'b1 || frame_tick !== 1'b1 || ack_cnt != 1) begin
            errors++; $display("FAIL t4_first_ack got ack=%b tick=%b cnt=%0d exp 1 1 1",
                               load_ack, frame_tick, ack_cnt);
        end
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (obs_cat[d] !== 8'hC0) begin
                errors++; $display("FAIL t4_zero_digit%0d got %h exp c0", d, obs_cat[d]);
            end
        end
        checks++;
        if (ack_cnt != 1 || load_ack !== 1'b1 || frame_tick !== 1'b1) begin
            errors++; $display("FAIL t4_second_ack got cnt=%0d ack=%b tick=%b exp 1 1 1",
                               ack_cnt, load_ack, frame_tick);
        end
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (obs_cat[d] !== 8'hA4) begin
                errors++; $display("FAIL t4_two_digit%0d got %h exp a4", d, obs_cat[d]);
            end
        end
        checks++;
        if (ack_cnt != 0) begin errors++; $display("FAIL t4_no_third_ack got %0d exp 0", ack_cnt); end
    endtask

    task automatic test_blank_dp();
        logic [7:0] exp [8];
        exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        ack_cnt = 0;
        load_word(32'h88888888, 8'hF0, 8'hFF);
        repeat (31) step();
        checks++;
        if (ack_cnt != 1 || load_ack !== 1'b1) begin
            errors++; $display("FAIL t5_ack got cnt=%0d ack=%b exp 1 1", ack_cnt, load_ack);
        end
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (obs_cat[d] !== exp[d]) begin
                errors++; $display("FAIL t5_digit%0d got %h exp %h", d, obs_cat[d], exp[d]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        load_word(32'h12345678, 8'h00, 8'h00);
        repeat (9) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel !== 3'd0 || cathode !== 8'hFF) begin
            errors++; $display("FAIL t6_async_reset got sel=%0d cat=%h exp 0 ff", sel, cathode);
        end
        checks++;
        if (load_ack !== 1'b0 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL t6_reset_pulses got ack=%b tick=%b exp 0 0", load_ack, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ack_cnt = 0;
        tick_cnt = 0;
        lit_cnt = 0;
        repeat (64) step();
        checks++;
        if (ack_cnt != 0) begin errors++; $display("FAIL t6_no_ack got %0d exp 0", ack_cnt); end
        checks++;
        if (lit_cnt != 0) begin errors++; $display("FAIL t6_dark got %0d lit cycles exp 0", lit_cnt); end
        checks++;
        if (tick_cnt != 2) begin errors++; $display("FAIL t6_ticks got %0d exp 2", tick_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ack_cnt = 0;
        tick_cnt = 0;
        lit_cnt = 0;
        test_reset();
        test_scan_idle();
        test_load_basic();
        test_last_wins();
        test_load_at_fb();
        test_blank_dp();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
